kbd_paddle_ctrl: RTL and testbench

Converts the PS/2 scan-code byte stream into ball-game control signals. It decodes make and break codes (plain and E0-extended), tracks held left/right keys, and moves the paddle once per 60 Hz tick, clamped to the play field. It also issues a one-cycle launch pulse on a fresh Space press. It sits between the PS/2 receiver and the game top, replacing the soft-processor path that supplied the paddle position and the launch flag.

---
 rtl/kbd_paddle_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_kbd_paddle_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_paddle_ctrl.sv
// rtl/kbd_paddle_ctrl.sv - PS/2 scan-code decoder driving paddle position and launch pulse
module kbd_paddle_ctrl #(
  parameter int PLAY_LEFT  = 100,
  parameter int PLAY_RIGHT = 540,
  parameter int HALF_LEN   = 30,
  parameter int INIT_LEF   = 300,
  parameter int STEP       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  kbd_byte,
  input  logic        kbd_valid,
  input  logic        tick_60,
  input  logic        lock,
  output logic [11:0] paddle_lef,
  output logic [11:0] paddle_half_len,
  output logic        launch,
  output logic        left_held,
  output logic        right_held,
  output logic [7:0]  last_code
);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_LARR  = 8'h6B;
  localparam logic [7:0] CODE_RARR  = 8'h74;
  localparam logic [7:0] CODE_A     = 8'h1C;
  localparam logic [7:0] CODE_D     = 8'h23;
  localparam logic [7:0] CODE_SPACE = 8'h29;

  // Movement bounds in 13-bit signed space so a step below zero stays negative
  localparam logic signed [12:0] LP_STEP  = 13'(STEP);
  localparam logic signed [12:0] LP_LEFT  = 13'(PLAY_LEFT);
  localparam logic signed [12:0] LP_RMAX  = 13'(PLAY_RIGHT - 2 * HALF_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_left_arrow;
  logic        r_left_letter;
  logic        r_right_arrow;
  logic        r_right_letter;
  logic        r_space_held;
  logic        r_launch;
  logic [7:0]  r_last_code;
  logic [11:0] r_paddle_lef;

  logic        w_done;
  logic        w_ext;
  logic        w_brk;
  logic        w_make;
  logic        w_hit_larr;
  logic        w_hit_a;
  logic        w_hit_rarr;
  logic        w_hit_d;
  logic        w_hit_space;
  logic        w_left;
  logic        w_right;
  logic signed [12:0] w_dec;
  logic signed [12:0] w_inc;
  logic signed [12:0] w_dec_clamped;
  logic signed [12:0] w_inc_clamped;

  // Classify the incoming byte: does it complete a code, and is it extended and/or a break
  always_comb begin
    w_done = 1'b0;
    w_ext  = 1'b0;
    w_brk  = 1'b0;
    if (kbd_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (kbd_byte != CODE_EXT && kbd_byte != CODE_BRK) begin
            w_done = 1'b1;
          end
        end
        ST_E0: begin
          if (kbd_byte != CODE_BRK) begin
            w_done = 1'b1;
            w_ext  = 1'b1;
          end
        end
        ST_F0: begin
          w_done = 1'b1;
          w_brk  = 1'b1;
        end
        ST_E0F0: begin
          w_done = 1'b1;
          w_ext  = 1'b1;
          w_brk  = 1'b1;
        end
        default: begin
          w_done = 1'b0;
        end
      endcase
    end
  end

  assign w_make      = ~w_brk;
  assign w_hit_larr  = w_done &  w_ext & (kbd_byte == CODE_LARR);
  assign w_hit_rarr  = w_done &  w_ext & (kbd_byte == CODE_RARR);
  assign w_hit_a     = w_done & ~w_ext & (kbd_byte == CODE_A);
  assign w_hit_d     = w_done & ~w_ext & (kbd_byte == CODE_D);
  assign w_hit_space = w_done & ~w_ext & (kbd_byte == CODE_SPACE);

  assign w_left  = r_left_arrow  | r_left_letter;
  assign w_right = r_right_arrow | r_right_letter;

  assign w_dec = $signed({1'b0, r_paddle_lef}) - LP_STEP;
  assign w_inc = $signed({1'b0, r_paddle_lef}) + LP_STEP;
  assign w_dec_clamped = (w_dec < LP_LEFT) ? LP_LEFT : w_dec;
  assign w_inc_clamped = (w_inc > LP_RMAX) ? LP_RMAX : w_inc;

  // Prefix tracker: remembers E0/F0 so the following byte is decoded in context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (kbd_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (kbd_byte == CODE_EXT) begin
            r_state <= ST_E0;
          end else if (kbd_byte == CODE_BRK) begin
            r_state <= ST_F0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_E0: begin
          r_state <= (kbd_byte == CODE_BRK) ? ST_E0F0 : ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Held flags: one per key source so releasing the arrow does not drop a held letter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left_arrow   <= 1'b0;
      r_left_letter  <= 1'b0;
      r_right_arrow  <= 1'b0;
      r_right_letter <= 1'b0;
      r_space_held   <= 1'b0;
    end else begin
      if (w_hit_larr)  r_left_arrow   <= w_make;
      if (w_hit_a)     r_left_letter  <= w_make;
      if (w_hit_rarr)  r_right_arrow  <= w_make;
      if (w_hit_d)     r_right_letter <= w_make;
      if (w_hit_space) r_space_held   <= w_make;
    end
  end

  // Launch fires only on the first Space make; typematic repeats see space already held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_launch <= 1'b0;
    end else begin
      r_launch <= w_hit_space & w_make & ~r_space_held & ~lock;
    end
  end

  // Display register captures every completed code, prefixes excluded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_code <= 8'h00;
    end else if (w_done) begin
      r_last_code <= kbd_byte;
    end
  end

  // Paddle moves one step per frame tick when exactly one direction is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_paddle_lef <= 12'(INIT_LEF);
    end else if (tick_60 && !lock) begin
      if (w_left && !w_right) begin
        r_paddle_lef <= w_dec_clamped[11:0];
      end else if (w_right && !w_left) begin
        r_paddle_lef <= w_inc_clamped[11:0];
      end
    end
  end

  assign paddle_lef      = r_paddle_lef;
  assign paddle_half_len = 12'(HALF_LEN);
  assign launch          = r_launch;
  assign left_held       = w_left;
  assign right_held      = w_right;
  assign last_code       = r_last_code;

endmodule

// File: tb/tb_kbd_paddle_ctrl.sv
// tb/tb_kbd_paddle_ctrl.sv - randomized self-checking bench for kbd_paddle_ctrl
module tb_kbd_paddle_ctrl;

  localparam int PL = 100;
  localparam int PR = 540;
  localparam int HL = 30;
  localparam int IL = 300;
  localparam int ST = 4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  kbd_byte;
  logic        kbd_valid;
  logic        tick_60;
  logic        lock;
  logic [11:0] paddle_lef;
  logic [11:0] paddle_half_len;
  logic        launch;
  logic        left_held;
  logic        right_held;
  logic [7:0]  last_code;

  int n_cmp;
  int n_bad;

  // Reference model state
  bit m_e0, m_f0;
  bit m_keys [string];
  int m_pos;
  bit m_launch;
  logic [7:0] m_last;

  kbd_paddle_ctrl #(
    .PLAY_LEFT(PL), .PLAY_RIGHT(PR), .HALF_LEN(HL), .INIT_LEF(IL), .STEP(ST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .kbd_byte(kbd_byte), .kbd_valid(kbd_valid),
    .tick_60(tick_60), .lock(lock), .paddle_lef(paddle_lef),
    .paddle_half_len(paddle_half_len), .launch(launch), .left_held(left_held),
    .right_held(right_held), .last_code(last_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_left();
    return m_keys["larr"] | m_keys["a"];
  endfunction

  function automatic bit m_right();
    return m_keys["rarr"] | m_keys["d"];
  endfunction

  task automatic model_clear();
    m_e0 = 0; m_f0 = 0;
    m_keys["larr"] = 0; m_keys["a"] = 0; m_keys["rarr"] = 0; m_keys["d"] = 0; m_keys["space"] = 0;
    m_pos = IL; m_launch = 0; m_last = 8'h00;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit t, input bit lk);
    bit make, ext;
    if (t && !lk) begin
      if (m_left() && !m_right()) m_pos = (m_pos - ST < PL) ? PL : m_pos - ST;
      if (m_right() && !m_left()) m_pos = (m_pos + ST > PR - 2*HL) ? PR - 2*HL : m_pos + ST;
    end
    m_launch = 0;
    if (v) begin
      if (b == 8'hE0 && !m_e0 && !m_f0) m_e0 = 1;
      else if (b == 8'hF0 && !m_f0) m_f0 = 1;
      else begin
        make = !m_f0;
        ext  = m_e0;
        m_last = b;
        if (ext && b == 8'h6B) m_keys["larr"] = make;
        if (ext && b == 8'h74) m_keys["rarr"] = make;
        if (!ext && b == 8'h1C) m_keys["a"] = make;
        if (!ext && b == 8'h23) m_keys["d"] = make;
        if (!ext && b == 8'h29) begin
          if (make && !m_keys["space"] && !lk) m_launch = 1;
          m_keys["space"] = make;
        end
        m_e0 = 0; m_f0 = 0;
      end
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] b, input bit t);
    kbd_valid = v; kbd_byte = b; tick_60 = t;
    model_step(v, b, t, lock);
    @(posedge clk); #1;
    kbd_valid = 0; tick_60 = 0; kbd_byte = 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1, b, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (paddle_lef !== 12'd300 || launch !== 1'b0 || left_held !== 1'b0 ||
        right_held !== 1'b0 || last_code !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_state: got pos=%0d launch=%b lh=%b rh=%b last=%h want 300 0 0 0 00",
               paddle_lef, launch, left_held, right_held, last_code);
    end
    n_cmp++;
    if (paddle_half_len !== 12'd30) begin
      n_bad++;
      $display("FAIL half_len: got %0d want 30", paddle_half_len);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 8'h00, 1);
      n_cmp++;
      if (paddle_lef !== 12'd300 || launch !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_ticks: got pos=%0d launch=%b want 300 0", paddle_lef, launch);
      end
    end
  endtask

  task automatic test_left_arrow();
    send(8'hE0); send(8'h6B);
    n_cmp++;
    if (left_held !== 1'b1 || last_code !== 8'h6B) begin
      n_bad++;
      $display("FAIL left_make: got lh=%b last=%h want 1 6b", left_held, last_code);
    end
    for (int i = 0; i < 10; i++) cyc(0, 8'h00, 1);
    n_cmp++;
    if (paddle_lef !== 12'd260) begin
      n_bad++;
      $display("FAIL left_move: got %0d want 260", paddle_lef);
    end
    send(8'hE0); send(8'hF0); send(8'h6B);
    n_cmp++;
    if (left_held !== 1'b0) begin
      n_bad++;
      $display("FAIL left_break: got lh=%b want 0", left_held);
    end
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1);
    n_cmp++;
    if (paddle_lef !== 12'd260) begin
      n_bad++;
      $display("FAIL left_released_hold: got %0d want 260", paddle_lef);
    end
  endtask

  task automatic test_right_saturate();
    bit over;
    send(8'h23);
    over = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(0, 8'h00, 1);
      if (paddle_lef > 12'd480) over = 1;
    end
    n_cmp++;
    if (paddle_lef !== 12'd480 || over) begin
      n_bad++;
      $display("FAIL right_clamp: got %0d exceeded=%b want 480 0", paddle_lef, over);
    end
    send(8'h1C);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1);
    n_cmp++;
    if (paddle_lef !== 12'd480 || left_held !== 1'b1 || right_held !== 1'b1) begin
      n_bad++;
      $display("FAIL both_held: got pos=%0d lh=%b rh=%b want 480 1 1", paddle_lef, left_held, right_held);
    end
  endtask

  task automatic test_space();
    int pulses;
    logic [7:0] seq [6];
    seq = '{8'h29, 8'h29, 8'h29, 8'hF0, 8'h29, 8'h29};
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      send(seq[i]);
      if (launch === 1'b1) pulses++;
      n_cmp++;
      if (launch !== m_launch) begin
        n_bad++;
        $display("FAIL space_pulse[%0d]: got %b want %b", i, launch, m_launch);
      end
      cyc(0, 8'h00, 0);
      n_cmp++;
      if (launch !== 1'b0) begin
        n_bad++;
        $display("FAIL space_one_cycle[%0d]: got %b want 0", i, launch);
      end
    end
    n_cmp++;
    if (pulses != 2) begin
      n_bad++;
      $display("FAIL space_count: got %0d want 2", pulses);
    end
  endtask

  task automatic test_lock();
    int pos0;
    bit any_launch;
    send(8'hF0); send(8'h29); send(8'hF0); send(8'h23); send(8'hF0); send(8'h1C);
    pos0 = int'(paddle_lef);
    lock = 1;
    any_launch = 0;
    send(8'h29); if (launch) any_launch = 1;
    send(8'hE0); send(8'h74);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 8'h00, 1);
      if (launch) any_launch = 1;
    end
    n_cmp++;
    if (any_launch || int'(paddle_lef) != pos0 || right_held !== 1'b1 || last_code !== 8'h74) begin
      n_bad++;
      $display("FAIL lock: got launch=%b pos=%0d rh=%b last=%h want 0 %0d 1 74",
               any_launch, paddle_lef, right_held, last_code, pos0);
    end
    lock = 0;
  endtask

  task automatic test_back_to_back();
    int pos0;
    send(8'hE0); send(8'hF0); send(8'h74);
    pos0 = int'(paddle_lef);
    cyc(1, 8'h23, 1);
    n_cmp++;
    if (int'(paddle_lef) != pos0 || right_held !== 1'b1) begin
      n_bad++;
      $display("FAIL same_cycle: got pos=%0d rh=%b want %0d 1", paddle_lef, right_held, pos0);
    end
    cyc(0, 8'h00, 1);
    n_cmp++;
    if (paddle_lef !== 12'(m_pos) || m_pos != (pos0 + ST > PR - 2*HL ? PR - 2*HL : pos0 + ST)) begin
      n_bad++;
      $display("FAIL next_tick: got %0d want %0d", paddle_lef, m_pos);
    end
  endtask

  task automatic test_reset_prefix();
    send(8'hE0);
    do_reset();
    send(8'h74);
    n_cmp++;
    if (right_held !== 1'b0 || last_code !== 8'h74 || paddle_lef !== 12'd300) begin
      n_bad++;
      $display("FAIL reset_prefix: got rh=%b last=%h pos=%0d want 0 74 300", right_held, last_code, paddle_lef);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [8];
    logic [7:0] b;
    logic [22:0] got, exp;
    bit v, t;
    pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h1C, 8'h23, 8'h29, 8'h00};
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) lock = ~lock;
      v = ($urandom_range(0, 2) != 0);
      t = ($urandom_range(0, 3) == 0);
      b = pool[$urandom_range(0, 7)];
      if (b == 8'h00) b = 8'($urandom);
      cyc(v, b, t);
      got = {paddle_lef, launch, left_held, right_held, last_code};
      exp = {12'(m_pos), m_launch, m_left(), m_right(), m_last};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL random[%0d]: got pos=%0d l=%b lh=%b rh=%b last=%h want pos=%0d l=%b lh=%b rh=%b last=%h",
                 i, got[22:11], got[10], got[9], got[8], got[7:0],
                 exp[22:11], exp[10], exp[9], exp[8], exp[7:0]);
      end
    end
    lock = 0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1; kbd_byte = 8'h00; kbd_valid = 0; tick_60 = 0; lock = 0;
    model_clear();
    #2;
    test_reset();
    test_left_arrow();
    test_right_saturate();
    test_space();
    test_lock();
    test_back_to_back();
    test_reset_prefix();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
